// File: rtl/soin_rv_pkg.sv
// Shared definitions for the SOIN-RV RV32I core: NOP encoding, default reset PC
// and the fetch-stage state encoding.
package soin_rv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with next-PC selection (reset/redirect/hold/+4).
// Optional misaligned-redirect detection is built when MISALIGN_CHECK_EN is defined.
module fetch_pc_reg
    import soin_rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] target,
`ifdef MISALIGN_CHECK_EN
    output logic        redirect_misaligned,
`endif
    output logic [31:0] pc
);

    logic [31:0] aligned_target;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        bad_target;

    assign aligned_target = target & 32'hFFFF_FFFC;
    assign pc_plus4       = pc + 32'd4;

`ifdef MISALIGN_CHECK_EN
    assign bad_target          = redirect && (target[1:0] != 2'b00);
    assign redirect_misaligned = bad_target;
`else
    assign bad_target          = 1'b0;
`endif

    // A misaligned redirect leaves the PC at its pre-redirect value.
    always_comb begin
        pc_next = pc;
        if (hold) begin
            pc_next = pc;
        end else if (redirect) begin
            if (!bad_target) begin
                pc_next = aligned_target;
            end
        end else if (!stall) begin
            pc_next = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives the instruction memory address and captures the IF/ID register.
// Define MISALIGN_CHECK_EN to add the sticky Misaligned flag and the HALT state.
module instruction_fetch
    import soin_rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] Addr,
    input  logic [31:0] Instruction,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Redirect,
    input  logic [31:0] Target,
    output logic [31:0] IfId_Instruction,
    output logic [31:0] IfId_Pc,
    output logic [31:0] IfId_PcPlus4,
    output logic        IfId_Valid
`ifdef MISALIGN_CHECK_EN
    ,
    output logic        Misaligned
`endif
);

    localparam logic [0:0] S_RUN  = RUN;
`ifdef MISALIGN_CHECK_EN
    localparam logic [0:0] S_HALT = HALT;
`endif

    logic [0:0]  state;
    logic        running;
    logic [31:0] pc;
`ifdef MISALIGN_CHECK_EN
    logic        redirect_misaligned;
`endif

    assign running = (state == S_RUN);
    assign Addr    = pc;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk                 (clk),
        .rst                 (rst),
        .hold                (!running),
        .stall               (Stall),
        .redirect            (Redirect),
        .target              (Target),
`ifdef MISALIGN_CHECK_EN
        .redirect_misaligned (redirect_misaligned),
`endif
        .pc                  (pc)
    );

    // Redirect outranks Flush, which outranks Stall, for the IF/ID register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_RUN;
            IfId_Instruction <= NOP_INSTR;
            IfId_Pc          <= 32'h0000_0000;
            IfId_PcPlus4     <= 32'h0000_0000;
            IfId_Valid       <= 1'b0;
`ifdef MISALIGN_CHECK_EN
            Misaligned       <= 1'b0;
`endif
        end else if (!running) begin
            IfId_Valid <= 1'b0;
        end else if (Redirect) begin
            IfId_Valid       <= 1'b0;
            IfId_Instruction <= NOP_INSTR;
`ifdef MISALIGN_CHECK_EN
            if (redirect_misaligned) begin
                Misaligned <= 1'b1;
                state      <= S_HALT;
            end
`endif
        end else if (Flush) begin
            IfId_Valid       <= 1'b0;
            IfId_Instruction <= NOP_INSTR;
        end else if (!Stall) begin
            IfId_Instruction <= Instruction;
            IfId_Pc          <= pc;
            IfId_PcPlus4     <= pc + 32'd4;
            IfId_Valid       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch, including a second instance
// with RESET_PC at the top of the address space to exercise PC wrap.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;

    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic [31:0] w_ifid_instr;
    logic [31:0] w_ifid_pc;
    logic [31:0] w_ifid_pc4;
    logic        w_ifid_valid;

`ifdef MISALIGN_CHECK_EN
    logic        misaligned;
    logic        w_misaligned;
`endif

    int num_checks;
    int num_fail;

    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0000_0000: imem = 32'h0050_0093;
            32'h0000_0004: imem = 32'h0010_0113;
            32'h0000_0008: imem = 32'h0020_8193;
            32'h0000_000C: imem = 32'h4011_0233;
            32'h0000_0040: imem = 32'h00A0_0513;
            32'h0000_0044: imem = 32'h00B0_0593;
            32'h0000_0048: imem = 32'h00C0_0613;
            32'h0000_004C: imem = 32'h00D0_0693;
            default:       imem = 32'hBAD0_0000 ^ a;
        endcase
    endfunction

    assign instr   = imem(addr);
    assign w_instr = imem(w_addr);

    instruction_fetch dut (
        .clk              (clk),
        .rst              (rst),
        .Addr             (addr),
        .Instruction      (instr),
        .Stall            (stall),
        .Flush            (flush),
        .Redirect         (redirect),
        .Target           (target),
        .IfId_Instruction (ifid_instr),
        .IfId_Pc          (ifid_pc),
        .IfId_PcPlus4     (ifid_pc4),
        .IfId_Valid       (ifid_valid)
`ifdef MISALIGN_CHECK_EN
        ,
        .Misaligned       (misaligned)
`endif
    );

    instruction_fetch #(
        .RESET_PC (32'hFFFF_FFFC)
    ) dut_wrap (
        .clk              (clk),
        .rst              (rst),
        .Addr             (w_addr),
        .Instruction      (w_instr),
        .Stall            (1'b0),
        .Flush            (1'b0),
        .Redirect         (1'b0),
        .Target           (32'h0000_0000),
        .IfId_Instruction (w_ifid_instr),
        .IfId_Pc          (w_ifid_pc),
        .IfId_PcPlus4     (w_ifid_pc4),
        .IfId_Valid       (w_ifid_valid)
`ifdef MISALIGN_CHECK_EN
        ,
        .Misaligned       (w_misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are sampled there too.
    task automatic applyStimulus(input logic s, input logic f, input logic r, input logic [31:0] t);
        stall    = s;
        flush    = f;
        redirect = r;
        target   = t;
        @(posedge clk);
        #1;
    endtask

    task automatic checkIfId(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_instr, input logic exp_valid);
        checkOutput({tag, "_pc"},    ifid_pc,    exp_pc);
        checkOutput({tag, "_pc4"},   ifid_pc4,   exp_pc + 32'd4);
        checkOutput({tag, "_instr"}, ifid_instr, exp_instr);
        checkOutput({tag, "_valid"}, {31'd0, ifid_valid}, {31'd0, exp_valid});
    endtask

    initial begin
        num_checks = 0;
        num_fail   = 0;
        rst        = 1'b1;
        stall      = 1'b0;
        flush      = 1'b0;
        redirect   = 1'b0;
        target     = 32'h0;
        #1;

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rst_addr",  addr, 32'h0);
        checkOutput("rst_instr", ifid_instr, 32'h0000_0013);
        checkOutput("rst_pc",    ifid_pc, 32'h0);
        checkOutput("rst_pc4",   ifid_pc4, 32'h0);
        checkOutput("rst_valid", {31'd0, ifid_valid}, 32'h0);
        checkOutput("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
`ifdef MISALIGN_CHECK_EN
        checkOutput("rst_misaligned", {31'd0, misaligned}, 32'h0);
`endif

        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkIfId("run0", 32'h0, 32'h0050_0093, 1'b1);
        checkOutput("run0_addr", addr, 32'h4);
        checkOutput("wrap_addr",  w_addr, 32'h0);
        checkOutput("wrap_pc",    w_ifid_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_pc4",   w_ifid_pc4, 32'h0);
        checkOutput("wrap_valid", {31'd0, w_ifid_valid}, 32'h1);

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkIfId("run1", 32'h4, 32'h0010_0113, 1'b1);
        checkOutput("run1_addr", addr, 32'h8);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
            checkOutput("stall_addr", addr, 32'h8);
            checkIfId("stall", 32'h4, 32'h0010_0113, 1'b1);
        end

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkIfId("run2", 32'h8, 32'h0020_8193, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkIfId("run3", 32'hC, 32'h4011_0233, 1'b1);
        checkOutput("run3_addr", addr, 32'h10);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h40);
        checkOutput("redir_addr",  addr, 32'h40);
        checkOutput("redir_valid", {31'd0, ifid_valid}, 32'h0);
        checkOutput("redir_instr", ifid_instr, 32'h0000_0013);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkIfId("redir_tgt", 32'h40, 32'h00A0_0513, 1'b1);
        checkOutput("redir_tgt_addr", addr, 32'h44);

        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("flush_stall_addr",  addr, 32'h44);
        checkOutput("flush_stall_valid", {31'd0, ifid_valid}, 32'h0);
        checkOutput("flush_stall_instr", ifid_instr, 32'h0000_0013);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkIfId("after_flush", 32'h44, 32'h00B0_0593, 1'b1);

        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("flush_addr",  addr, 32'h4C);
        checkOutput("flush_valid", {31'd0, ifid_valid}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkIfId("after_flush2", 32'h4C, 32'h00D0_0693, 1'b1);

        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h80);
        checkOutput("midrst_addr",  addr, 32'h0);
        checkOutput("midrst_valid", {31'd0, ifid_valid}, 32'h0);
        checkOutput("midrst_pc",    ifid_pc, 32'h0);
        rst = 1'b0;

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkIfId("post_rst", 32'h0, 32'h0050_0093, 1'b1);

        applyStimulus(1'b0, 1'b0, 1'b1, 32'h42);
        checkOutput("mis_valid", {31'd0, ifid_valid}, 32'h0);
`ifdef MISALIGN_CHECK_EN
        checkOutput("mis_flag", {31'd0, misaligned}, 32'h1);
        checkOutput("mis_addr", addr, 32'h4);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, (i == 1), 32'h40);
            checkOutput("halt_valid", {31'd0, ifid_valid}, 32'h0);
            checkOutput("halt_addr",  addr, 32'h4);
            checkOutput("halt_flag",  {31'd0, misaligned}, 32'h1);
        end
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        checkOutput("halt_rst_flag", {31'd0, misaligned}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkIfId("halt_exit", 32'h0, 32'h0050_0093, 1'b1);
`else
        checkOutput("mis_addr", addr, 32'h40);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkIfId("mis_tgt", 32'h40, 32'h00A0_0513, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_checks, num_fail);
        $finish;
    end

endmodule
